// File: rtl/intr_aggregator.sv
// intr_aggregator: synchronises NUM_IN interrupt sources, latches them per channel (level or edge)
// and routes them onto NUM_OUT core interrupt lines, configured through a single-beat register port.
module intr_aggregator #(
    parameter int NUM_IN      = 8,
    parameter int NUM_OUT     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               uncoreclk,
    input  logic               uncore_rstn,
    input  logic [NUM_IN-1:0]  irq_in,
    output logic [NUM_OUT-1:0] irq_out,
    input  logic               reg_valid,
    output logic               reg_ready,
    input  logic               reg_we,
    input  logic [5:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic               reg_rvalid,
    output logic [31:0]        reg_rdata
);
    localparam int RW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;

    logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync;
    logic [NUM_IN-1:0][RW-1:0]          route;
    logic [NUM_IN-1:0] s, s_d, rise, pending, enable, mode, overrun, wd;
    logic [NUM_IN-1:0] w1c, ovr_w1c, mode_nx, enable_nx, to_edge, pending_nx, overrun_nx;
    logic [NUM_OUT-1:0] irq_nx;
    logic [RW-1:0]      route_wv;
    logic [31:0]        rdata_nx;
    logic               acc, wr, rd, route_we;

    assign acc        = reg_valid & reg_ready;
    assign wr         = acc & reg_we;
    assign rd         = acc & ~reg_we;
    assign route_we   = wr & reg_addr[5];
    assign wd         = reg_wdata[NUM_IN-1:0];
    assign s          = sync[SYNC_STAGES-1];
    assign rise       = s & ~s_d;
    assign w1c        = (wr && reg_addr == 6'h00) ? wd & mode : '0;
    assign ovr_w1c    = (wr && reg_addr == 6'h03) ? wd : '0;
    assign mode_nx    = (wr && reg_addr == 6'h02) ? wd : mode;
    assign enable_nx  = (wr && reg_addr == 6'h01) ? wd : enable;
    assign to_edge    = mode_nx & ~mode;
    assign route_wv   = (reg_wdata >= 32'(NUM_OUT)) ? RW'(NUM_OUT - 1) : reg_wdata[RW-1:0];
    // A fresh rise beats a same-cycle W1C; a level->edge switch drops whatever was latched.
    assign pending_nx = ((mode & (rise | (pending & ~w1c))) | (~mode & s)) & ~to_edge;
    assign overrun_nx = (overrun & ~ovr_w1c) | (mode & rise & pending & ~w1c);

    always_comb begin
        irq_nx = '0;
        for (int i = 0; i < NUM_IN; i++)
            for (int j = 0; j < NUM_OUT; j++)
                if (pending[i] && enable[i] && route[i] == RW'(j)) irq_nx[j] = 1'b1;
    end

    always_comb begin
        rdata_nx = '0;
        case (reg_addr)
            6'h00:   rdata_nx[NUM_IN-1:0] = pending;
            6'h01:   rdata_nx[NUM_IN-1:0] = enable;
            6'h02:   rdata_nx[NUM_IN-1:0] = mode;
            6'h03:   rdata_nx[NUM_IN-1:0] = overrun;
            6'h04:   rdata_nx = {8'h0, 8'(SYNC_STAGES), 8'(NUM_OUT), 8'(NUM_IN)};
            default:
                for (int k = 0; k < NUM_IN; k++)
                    if (reg_addr == 6'(32 + k)) rdata_nx[RW-1:0] = route[k];
        endcase
    end

    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            sync       <= '0;
            s_d        <= '0;
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            overrun    <= '0;
            route      <= '0;
            irq_out    <= '0;
            reg_ready  <= 1'b0;
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], irq_in};
            s_d        <= s;
            pending    <= pending_nx;
            overrun    <= overrun_nx;
            mode       <= mode_nx;
            enable     <= enable_nx;
            irq_out    <= irq_nx;
            reg_ready  <= 1'b1;
            reg_rvalid <= rd;
            reg_rdata  <= rd ? rdata_nx : reg_rdata;
            for (int k = 0; k < NUM_IN; k++)
                if (route_we && reg_addr[4:0] == 5'(k)) route[k] <= route_wv;
        end
    end
endmodule

// File: tb/tb_intr_aggregator.sv
// tb_intr_aggregator: register-table vectors plus directed multi-cycle sequences for intr_aggregator.
module tb_intr_aggregator;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  irq_in = '0;
    logic [1:0]  irq_out;
    logic        reg_valid = 1'b0, reg_ready, reg_we = 1'b0, reg_rvalid;
    logic [5:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0, reg_rdata;
    int          total = 0, bad = 0;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[23];

    always #5 clk = ~clk;

    intr_aggregator dut (
        .uncoreclk(clk), .uncore_rstn(rst_n), .irq_in(irq_in), .irq_out(irq_out),
        .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        reg_valid = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_valid = 1'b0; reg_we = 1'b0;
    endtask

    task automatic rchk(input string name, input logic [5:0] a, input logic [31:0] e);
        reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a;
        step();
        reg_valid = 1'b0;
        chk({name, "_rvalid"}, {31'b0, reg_rvalid}, 32'd1);
        chk(name, reg_rdata, e);
    endtask

    task automatic pulse(input int ch);
        irq_in[ch] = 1'b1;
        step();
        irq_in[ch] = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 6'h00, 32'h0};
        tbl[1]  = '{1'b0, 6'h01, 32'h0};
        tbl[2]  = '{1'b0, 6'h02, 32'h0};
        tbl[3]  = '{1'b0, 6'h03, 32'h0};
        tbl[4]  = '{1'b0, 6'h04, 32'h0002_0208};
        tbl[5]  = '{1'b0, 6'h05, 32'h0};
        tbl[6]  = '{1'b1, 6'h01, 32'hFFFF_FFFF};
        tbl[7]  = '{1'b0, 6'h01, 32'h0000_00FF};
        tbl[8]  = '{1'b1, 6'h01, 32'h0};
        tbl[9]  = '{1'b1, 6'h21, 32'h7};
        tbl[10] = '{1'b0, 6'h21, 32'h1};
        tbl[11] = '{1'b1, 6'h21, 32'h0};
        tbl[12] = '{1'b0, 6'h21, 32'h0};
        tbl[13] = '{1'b1, 6'h28, 32'h1};
        tbl[14] = '{1'b0, 6'h28, 32'h0};
        tbl[15] = '{1'b1, 6'h04, 32'hFFFF_FFFF};
        tbl[16] = '{1'b0, 6'h04, 32'h0002_0208};
        tbl[17] = '{1'b1, 6'h3F, 32'h5};
        tbl[18] = '{1'b0, 6'h3F, 32'h0};
        tbl[19] = '{1'b1, 6'h02, 32'h1FF};
        tbl[20] = '{1'b0, 6'h02, 32'hFF};
        tbl[21] = '{1'b1, 6'h02, 32'h0};
        tbl[22] = '{1'b0, 6'h02, 32'h0};

        // reset with all sources asserted
        irq_in = 8'hFF;
        step(3);
        chk("rst_irq_out", {30'b0, irq_out}, 32'h0);
        chk("rst_ready", {31'b0, reg_ready}, 32'h0);
        chk("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
        rst_n = 1'b1;
        irq_in = '0;
        step();
        chk("ready_after_rst", {31'b0, reg_ready}, 32'h1);

        for (int i = 0; i < 23; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].data);
            else rchk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data);
        end

        // level mode on channel 0
        wr(6'h01, 32'h1);
        irq_in[0] = 1'b1;
        step(3);
        chk("lvl_rise_early", {30'b0, irq_out}, 32'h0);
        step();
        chk("lvl_rise_4", {30'b0, irq_out}, 32'h1);
        irq_in[0] = 1'b0;
        step(3);
        chk("lvl_fall_early", {30'b0, irq_out}, 32'h1);
        step();
        chk("lvl_fall_4", {30'b0, irq_out}, 32'h0);
        irq_in[0] = 1'b1;
        step(4);
        wr(6'h00, 32'h1);
        step();
        chk("lvl_w1c_ignored", {30'b0, irq_out}, 32'h1);
        rchk("lvl_pending", 6'h00, 32'h1);
        irq_in[0] = 1'b0;
        step(4);
        rchk("lvl_pending_drop", 6'h00, 32'h0);

        // edge mode, W1C on channel 1
        wr(6'h02, 32'h2);
        wr(6'h01, 32'h2);
        wr(6'h21, 32'h1);
        pulse(1);
        step(3);
        chk("edge_set", {30'b0, irq_out}, 32'h2);
        step(3);
        chk("edge_held", {30'b0, irq_out}, 32'h2);
        wr(6'h00, 32'h2);
        chk("edge_w1c_lag", {30'b0, irq_out}, 32'h2);
        step();
        chk("edge_w1c_out", {30'b0, irq_out}, 32'h0);
        rchk("edge_w1c_pend", 6'h00, 32'h0);

        // rise colliding with W1C: set wins, no overrun
        pulse(1);
        step(4);
        chk("coll_pre", {30'b0, irq_out}, 32'h2);
        irq_in[1] = 1'b1;
        step();
        irq_in[1] = 1'b0;
        step();
        reg_valid = 1'b1; reg_we = 1'b1; reg_addr = 6'h00; reg_wdata = 32'h2;
        step();
        reg_valid = 1'b0; reg_we = 1'b0;
        rchk("coll_pend", 6'h00, 32'h2);
        rchk("coll_ovr", 6'h03, 32'h0);
        pulse(1);
        step(4);
        rchk("ovr_set", 6'h03, 32'h2);
        wr(6'h03, 32'h2);
        rchk("ovr_w1c", 6'h03, 32'h0);
        wr(6'h00, 32'h2);
        rchk("pend_clr", 6'h00, 32'h0);

        // level->edge switch clears a latched level
        irq_in[2] = 1'b1;
        step(4);
        rchk("mode_pre", 6'h00, 32'h4);
        wr(6'h02, 32'h6);
        rchk("mode_switch_clr", 6'h00, 32'h0);
        irq_in[2] = 1'b0;
        wr(6'h02, 32'h2);
        step(3);

        // masked edge channel 5, route clamp, re-enable
        wr(6'h01, 32'h0);
        wr(6'h02, 32'h22);
        pulse(5);
        step(5);
        chk("mask_out", {30'b0, irq_out}, 32'h0);
        rchk("mask_pend", 6'h00, 32'h20);
        wr(6'h25, 32'h7);
        rchk("route_clamp", 6'h25, 32'h1);
        wr(6'h01, 32'h20);
        chk("unmask_lag", {30'b0, irq_out}, 32'h0);
        step();
        chk("unmask_out", {30'b0, irq_out}, 32'h2);

        // asynchronous reset mid-operation
        wr(6'h01, 32'h21);
        irq_in[0] = 1'b1;
        step(4);
        chk("both_out", {30'b0, irq_out}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {30'b0, irq_out}, 32'h0);
        chk("async_rst_ready", {31'b0, reg_ready}, 32'h0);
        step(2);
        irq_in = '0;
        rst_n = 1'b1;
        step();
        rchk("post_pend", 6'h00, 32'h0);
        rchk("post_en", 6'h01, 32'h0);
        rchk("post_mode", 6'h02, 32'h0);
        rchk("post_ovr", 6'h03, 32'h0);
        rchk("post_route5", 6'h25, 32'h0);
        rchk("post_route1", 6'h21, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
